// File: rtl/pipe_types_pkg.sv
// Shared types and defaults for the elastic pipeline stage register.
package pipe_types_pkg;

  localparam int unsigned PIPE_WIDTH_DEF = 32;
  localparam int unsigned PIPE_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: in_ready and out_valid decode from state only,
// so no input reaches any output combinationally.
module pipe_skid_buf
  import pipe_types_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
          end
        end
        TWO: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = RESET_VAL;
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register (single register or skid buffer by SKID).
// Define PIPE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_reg
  import pipe_types_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH_DEF,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W must be at least 1");
  end

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush)
    );
  end else begin : g_reg
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire, out_fire;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = valid_q & out_ready;

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
        main_d  = RESET_VAL;
      end else if (in_fire) begin
        valid_d = 1'b1;
        main_d  = in_data;
      end else if (out_fire) begin
        valid_d = 1'b0;
        main_d  = RESET_VAL;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (out_valid || in_valid) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: SKID=0 and SKID=1 instances share
// stimulus; a queue scoreboard per instance plus directed SKID=1 vectors.
module tb_pipe_stage_reg;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'hF00F;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST, in_valid, out_ready, flush;
  logic [W-1:0] in_data;
  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [W-1:0] out_data0, out_data1;
`ifdef PIPE_PERF_EN
  logic [3:0]   stall0, flushc0, stall1, flushc1;
`endif

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .RESET_VAL(RV), .CNT_W(4)) dut0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .flush(flush)
`ifdef PIPE_PERF_EN
    , .perf_stall_cnt(stall0), .perf_flush_cnt(flushc0)
`endif
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .RESET_VAL(RV), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .flush(flush)
`ifdef PIPE_PERF_EN
    , .perf_stall_cnt(stall1), .perf_flush_cnt(flushc1)
`endif
  );

  typedef struct {
    logic         rst, iv;
    logic [W-1:0] id;
    logic         ordy, fl;
    logic         ck;          // check SKID=1 outputs after this edge
    logic         ev;
    logic [W-1:0] ed;
    logic         er;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic addv(input logic rst, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic fl, input logic ck,
                      input logic ev, input logic [W-1:0] ed, input logic er);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ck = ck; v.ev = ev; v.ed = ed; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v);
    logic         rdy0, rdy1, of0, of1;
    logic [W-1:0] d0, d1, exp_d;
    @(negedge CLK);
    RST = v.rst; in_valid = v.iv; in_data = v.id; out_ready = v.ordy; flush = v.fl;
    #1;
    rdy0 = (q0.size() == 0) || v.ordy;
    rdy1 = (q1.size() < 2);
    of0  = (q0.size() > 0) && v.ordy;
    of1  = (q1.size() > 0) && v.ordy;
    d0   = out_data0;
    d1   = out_data1;
    if (!v.rst) begin
      chk("s0_in_ready", in_ready0, rdy0);
      chk("s1_in_ready", in_ready1, rdy1);
      chk("s0_out_valid", out_valid0, q0.size() > 0);
      chk("s1_out_valid", out_valid1, q1.size() > 0);
      if (q0.size() == 0) chk("s0_idle_data", d0, RV);
      if (q1.size() == 0) chk("s1_idle_data", d1, RV);
    end
    @(posedge CLK);
    if (v.rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (of0) begin exp_d = q0.pop_front(); chk("s0_sb_data", d0, exp_d); end
      if (of1) begin exp_d = q1.pop_front(); chk("s1_sb_data", d1, exp_d); end
      if (v.fl) begin
        q0.delete();
        q1.delete();
      end else begin
        if (v.iv && rdy0) q0.push_back(v.id);
        if (v.iv && rdy1) q1.push_back(v.id);
      end
    end
    #1;
    if (v.ck) begin
      chk("s1_vec_out_valid", out_valid1, v.ev);
      chk("s1_vec_out_data", out_data1, v.ed);
      chk("s1_vec_in_ready", in_ready1, v.er);
    end
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // reset
    addv(1, 0, 0, 1, 0, 1, 0, RV, 1);
    addv(1, 0, 0, 1, 0, 1, 0, RV, 1);
    // streaming 1..8, no gaps
    for (int i = 1; i <= 8; i++) addv(0, 1, W'(i), 1, 0, 1, 1, W'(i), 1);
    addv(0, 0, 0, 1, 0, 1, 0, RV, 1);
    // backpressure: A then B into a stalled stage
    addv(0, 1, 16'h000A, 0, 0, 1, 1, 16'h000A, 1);
    addv(0, 1, 16'h000B, 0, 0, 1, 1, 16'h000A, 0);
    addv(0, 0, 16'h0000, 0, 0, 1, 1, 16'h000A, 0);
    addv(0, 0, 16'h0000, 1, 0, 1, 1, 16'h000B, 1);
    addv(0, 0, 16'h0000, 1, 0, 1, 0, RV, 1);
    // flush while full, with 0xC offered in the same cycle
    addv(0, 1, 16'h000E, 0, 0, 1, 1, 16'h000E, 1);
    addv(0, 1, 16'h000F, 0, 0, 1, 1, 16'h000E, 0);
    addv(0, 1, 16'h000C, 0, 1, 1, 0, RV, 1);
    addv(0, 0, 16'h0000, 1, 0, 1, 0, RV, 1);
    // flush coinciding with out fire, then accept right after
    addv(0, 1, 16'h0011, 1, 0, 1, 1, 16'h0011, 1);
    addv(0, 0, 16'h0000, 1, 1, 1, 0, RV, 1);
    addv(0, 1, 16'h0012, 1, 0, 1, 1, 16'h0012, 1);
    addv(0, 0, 16'h0000, 1, 0, 1, 0, RV, 1);
    // reset mid-transfer
    addv(0, 1, 16'h0021, 0, 0, 1, 1, 16'h0021, 1);
    addv(1, 1, 16'h0022, 0, 0, 1, 0, RV, 1);
    addv(0, 0, 16'h0000, 1, 0, 1, 0, RV, 1);
    run_tbl();

    // random traffic checked by the scoreboard only
    for (int i = 0; i < 60; i++)
      addv(0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_tbl();
    chk("s0_drained", q0.size(), 0);
    chk("s1_drained", q1.size(), 0);

`ifdef PIPE_PERF_EN
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tbl();
    chk("s0_stall_reset", stall0, 0);
    chk("s1_flush_reset", flushc1, 0);
    addv(0, 1, 16'h0031, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) addv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_tbl();
    chk("s0_stall_sat", stall0, 15);
    chk("s1_stall_sat", stall1, 15);
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      addv(0, 1, W'(16'h40 + k), 1, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    run_tbl();
    chk("s0_flush_cnt", flushc0, 3);
    chk("s1_flush_cnt", flushc1, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
